seq_shift_add_mult: RTL and testbench

- Sequential radix-2 shift-add multiplier datapath and controller.
- Directly consumes the (N+1)-bit 2:1 select mux output: each cycle it chooses between "accumulator + multiplicand" and "accumulator unchanged" based on the multiplier LSB.
- It then registers and right-shifts the result.
- Produces an unsigned 2N-bit product after N iteration cycles, with a start/done handshake to the pipeline control.

---
 rtl/mult_pkg.sv | 18 +
 rtl/MUX17BIT2_1.sv | 19 +
 rtl/seq_shift_add_mult.sv | 104 ++++++++++
 tb/tb_seq_shift_add_mult.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: controller states,
// default operand width and the iteration-counter width helper.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_N = 16;

    // Counter must be able to hold values 0..N.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/MUX17BIT2_1.sv
// (n+1)-bit 2:1 select mux: out = sel ? data1 : data0.
// Kept as its own block so it can be verified apart from the accumulator.
module MUX17BIT2_1 #(
    parameter int n = 16
) (
    input  logic [n:0] data0,
    input  logic [n:0] data1,
    input  logic       sel,
    output logic [n:0] out
);

    genvar gi;
    generate
        for (gi = 0; gi <= n; gi++) begin : g_bit
            assign out[gi] = sel ? data1[gi] : data0[gi];
        end
    endgenerate

endmodule

// File: rtl/seq_shift_add_mult.sv
// Radix-2 shift-add multiplier: N RUN cycles per unsigned N x N product, with a
// start/done handshake and back-to-back acceptance from the DONE state.
module seq_shift_add_mult
    import mult_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int CW = cnt_width(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    state_t        state_reg;
    logic [N-1:0]  m_reg;
    logic [N-1:0]  a_reg;
    logic [N-1:0]  q_reg;
    logic [CW-1:0] cnt_reg;
    logic          busy_reg;
    logic          done_reg;

    logic [N:0]    sum;
    logic [N:0]    sel_out;

    // Carry is kept so the full 2N-bit product always fits.
    assign sum = {1'b0, a_reg} + {1'b0, m_reg};

    MUX17BIT2_1 #(
        .n(N)
    ) u_sel_mux (
        .data0 ({1'b0, a_reg}),
        .data1 (sum),
        .sel   (q_reg[0]),
        .out   (sel_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            m_reg     <= '0;
            a_reg     <= '0;
            q_reg     <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        m_reg     <= multiplicand;
                        q_reg     <= multiplier;
                        a_reg     <= '0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    // {A,Q} takes the mux result shifted right by one; the
                    // mux MSB (adder carry) lands in A[N-1].
                    a_reg   <= sel_out[N:1];
                    q_reg   <= {sel_out[0], q_reg[N-1:1]};
                    cnt_reg <= cnt_reg + CW'(1);
                    if (cnt_reg == LAST_ITER) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        m_reg     <= multiplicand;
                        q_reg     <= multiplier;
                        a_reg     <= '0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign product = {a_reg, q_reg};

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Self-checking bench for seq_shift_add_mult: directed cases plus 1000 random
// operand pairs against a plain-arithmetic reference model.
module tb_seq_shift_add_mult;

    localparam int N = 16;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [N-1:0]  mc;
    logic [N-1:0]  mp;
    logic          busy;
    logic          done;
    logic [2*N-1:0] product;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    seq_shift_add_mult #(.N(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (mc),
        .multiplier   (mp),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: a request seen while not computing starts an N-edge
    // computation whose result is the plain product of the captured operands.
    logic [2*N-1:0] m_exp;
    logic [2*N-1:0] m_prod;
    int             m_rem;
    bit             m_run;
    bit             m_done;
    bit             m_hold;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run  <= 1'b0;
            m_done <= 1'b0;
            m_hold <= 1'b1;
            m_prod <= '0;
            m_exp  <= '0;
            m_rem  <= 0;
        end else if (m_run) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
                m_run  <= 1'b0;
                m_done <= 1'b1;
                m_hold <= 1'b1;
                m_prod <= m_exp;
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_exp  <= {{N{1'b0}}, mc} * {{N{1'b0}}, mp};
                m_run  <= 1'b1;
                m_rem  <= N;
                m_hold <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check("busy_vs_model", 64'(busy), 64'(m_run));
        check("done_vs_model", 64'(done), 64'(m_done));
        if (m_hold)
            check("product_vs_model", 64'(product), 64'(m_prod));
    end

    // Issue one operation; the caller guarantees the DUT is not in RUN.
    // inject_at >= 0 pulses a bogus request (7x7) after that many RUN edges.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [2*N-1:0] exp, input bit junk, input int inject_at);
        int edges;
        @(negedge clk);
        start = 1'b1;
        mc    = a;
        mp    = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        mc    = N'($urandom);
        mp    = N'($urandom);
        check("accept_busy", 64'(busy), 64'd1);
        edges = 0;
        while (!done && edges < N + 4) begin
            if (edges == inject_at) begin
                start = 1'b1;
                mc    = 16'd7;
                mp    = 16'd7;
            end else if (junk && edges < N - 1) begin
                start = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            edges++;
        end
        start = 1'b0;
        check("latency", 64'(edges), 64'(N));
        check("product", 64'(product), 64'(exp));
        n_txn++;
        $display("txn %0d: 0x%04h * 0x%04h = 0x%08h (expect 0x%08h) latency %0d",
                 n_txn, a, b, product, exp, edges);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        rst_n = 1'b0;
        start = 1'b0;
        mc    = '0;
        mp    = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_product", 64'(product), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op(16'd3, 16'd5, 32'h0000_000F, 1'b0, -1);
        repeat (2) @(negedge clk);
        run_op(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, -1);
        run_op(16'h0000, 16'h1234, 32'h0000_0000, 1'b0, -1);

        // Request while busy must be ignored and give a single done pulse.
        repeat (3) @(negedge clk);
        run_op(16'h00FF, 16'h0101, 32'h0000_FFFF, 1'b0, 5);
        @(posedge clk);
        #1;
        check("single_done", 64'(done), 64'd0);

        // Back-to-back: second request issued during the DONE cycle.
        repeat (2) @(negedge clk);
        run_op(16'h0FF0, 16'h0003, 32'h0000_2FD0, 1'b0, -1);
        run_op(16'h1234, 16'h0010, 32'h0001_2340, 1'b0, -1);

        // Asynchronous reset in the middle of a computation.
        repeat (2) @(negedge clk);
        start = 1'b1;
        mc    = 16'hAAAA;
        mp    = 16'h5555;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_product", 64'(product), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("after_rst_busy", 64'(busy), 64'd0);
        run_op(16'd2, 16'd3, 32'd6, 1'b0, -1);

        for (int i = 0; i < 1000; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? 16'hFFFF : N'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'hFFFF : N'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(ra, rb, {{N{1'b0}}, ra} * {{N{1'b0}}, rb}, 1'b1, -1);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
